// File: rtl/host_loader_if.sv
`default_nettype none
// ============================================================================
//  host_loader_if
//  Signal bundle between the host loader and the processor memories / host
//  byte streams. The master modport is the loader side, the slave modport is
//  the side of the byte bridge and the processor.
//  Revision: 1.0
// ============================================================================
interface host_loader_if #(
  parameter int WIDTH_ACT_MEM    = 8,
  parameter int WIDTH_PARAM_MEM  = 128,
  parameter int WIDTH_INST_MEM   = 80,
  parameter int WIDTH_ADDR_ACT   = 12,
  parameter int WIDTH_ADDR_PARAM = 15,
  parameter int WIDTH_ADDR_INST  = 6
) ();
  logic [7:0]                  s_data;
  logic                        s_valid;
  logic                        s_ready;
  logic [7:0]                  m_data;
  logic                        m_valid;
  logic                        m_ready;
  logic                        sel_ext;
  logic                        en;
  logic                        done;
  logic                        wea_instmem_ext;
  logic                        wea_parammem_ext;
  logic                        wea_actmem_ext;
  logic [WIDTH_INST_MEM-1:0]   instmem_in_ext;
  logic [WIDTH_PARAM_MEM-1:0]  parammem_in_ext;
  logic [WIDTH_ACT_MEM-1:0]    actmem_in_ext;
  logic [WIDTH_ADDR_INST-1:0]  addr_instmem_ext;
  logic [WIDTH_ADDR_PARAM-1:0] addr_parammem_ext;
  logic [WIDTH_ADDR_ACT-1:0]   addr_actmem_ext;
  logic [WIDTH_ACT_MEM-1:0]    actmem_out;
  logic                        busy;
  logic                        err;

  modport master (
    input  s_data, s_valid, m_ready, done, actmem_out,
    output s_ready, m_data, m_valid, sel_ext, en,
    output wea_instmem_ext, wea_parammem_ext, wea_actmem_ext,
    output instmem_in_ext, parammem_in_ext, actmem_in_ext,
    output addr_instmem_ext, addr_parammem_ext, addr_actmem_ext,
    output busy, err
  );

  modport slave (
    output s_data, s_valid, m_ready, done, actmem_out,
    input  s_ready, m_data, m_valid, sel_ext, en,
    input  wea_instmem_ext, wea_parammem_ext, wea_actmem_ext,
    input  instmem_in_ext, parammem_in_ext, actmem_in_ext,
    input  addr_instmem_ext, addr_parammem_ext, addr_actmem_ext,
    input  busy, err
  );
endinterface
`default_nettype wire

// File: rtl/host_loader.sv
`default_nettype none
// ============================================================================
//  host_loader
//  Byte-stream command engine that loads instruction/parameter/activation
//  memories of the processor, starts a run, and streams activation memory
//  back out as bytes.
//  Revision: 1.0
// ============================================================================
module host_loader #(
  parameter int WIDTH_ACT_MEM    = 8,
  parameter int WIDTH_PARAM_MEM  = 128,
  parameter int WIDTH_INST_MEM   = 80,
  parameter int WIDTH_ADDR_ACT   = 12,
  parameter int WIDTH_ADDR_PARAM = 15,
  parameter int WIDTH_ADDR_INST  = 6
) (
  input  logic          clk,
  input  logic          resetn,
  host_loader_if.master bus
);
  // Packing buffer is sized for the widest word; byte index addresses it.
  localparam int BUF_W  = (WIDTH_PARAM_MEM > WIDTH_INST_MEM) ? WIDTH_PARAM_MEM : WIDTH_INST_MEM;
  localparam int BIDX_W = $clog2(BUF_W / 8);
  localparam int BASE_W = (WIDTH_ADDR_PARAM > WIDTH_ADDR_ACT) ?
                          ((WIDTH_ADDR_PARAM > WIDTH_ADDR_INST) ? WIDTH_ADDR_PARAM : WIDTH_ADDR_INST) :
                          ((WIDTH_ADDR_ACT > WIDTH_ADDR_INST) ? WIDTH_ADDR_ACT : WIDTH_ADDR_INST);

  localparam logic [BIDX_W-1:0] LAST_INST  = BIDX_W'(WIDTH_INST_MEM / 8 - 1);
  localparam logic [BIDX_W-1:0] LAST_PARAM = BIDX_W'(WIDTH_PARAM_MEM / 8 - 1);
  localparam logic [BIDX_W-1:0] LAST_ACT   = BIDX_W'(WIDTH_ACT_MEM / 8 - 1);

  localparam logic [7:0] OP_WR_INST  = 8'h01;
  localparam logic [7:0] OP_WR_PARAM = 8'h02;
  localparam logic [7:0] OP_WR_ACT   = 8'h03;
  localparam logic [7:0] OP_RUN      = 8'h04;
  localparam logic [7:0] OP_RD_ACT   = 8'h05;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_RD_ADDR = 3'd5;
  localparam logic [2:0] S_RD_WAIT = 3'd6;
  localparam logic [2:0] S_RD_OUT  = 3'd7;

  logic [2:0]                  state_q, state_d;
  logic [7:0]                  op_q, op_d;
  logic [1:0]                  hdr_q, hdr_d;
  logic [BASE_W-1:0]           base_q, base_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic [15:0]                 widx_q, widx_d;
  logic [BIDX_W-1:0]           bidx_q, bidx_d;
  logic [BUF_W-1:0]            buf_q, buf_d;
  logic                        rdy_q, rdy_d;
  logic                        sel_q, sel_d;
  logic                        en_q, en_d;
  logic                        wea_inst_q, wea_inst_d;
  logic                        wea_param_q, wea_param_d;
  logic                        wea_act_q, wea_act_d;
  logic [WIDTH_INST_MEM-1:0]   inst_data_q, inst_data_d;
  logic [WIDTH_PARAM_MEM-1:0]  param_data_q, param_data_d;
  logic [WIDTH_ACT_MEM-1:0]    act_data_q, act_data_d;
  logic [WIDTH_ADDR_INST-1:0]  addr_inst_q, addr_inst_d;
  logic [WIDTH_ADDR_PARAM-1:0] addr_param_q, addr_param_d;
  logic [WIDTH_ADDR_ACT-1:0]   addr_act_q, addr_act_d;
  logic [7:0]                  m_data_q, m_data_d;
  logic                        m_valid_q, m_valid_d;
  logic                        err_q, err_d;

  logic                        w_s_ready;
  logic                        w_s_fire;
  logic [BIDX_W-1:0]           w_last_bidx;
  logic [15:0]                 w_nidx;

  // Byte input is open only in the byte-consuming states, and never during reset.
  always_comb begin
    w_s_ready = rdy_q & ((state_q == S_IDLE) | (state_q == S_HDR) | (state_q == S_LOAD));
    w_s_fire  = w_s_ready & bus.s_valid;
    w_nidx    = widx_q + 16'd1;
  end

  // Last byte index of a payload word depends on the target memory.
  always_comb begin
    case (op_q)
      OP_WR_INST:  w_last_bidx = LAST_INST;
      OP_WR_PARAM: w_last_bidx = LAST_PARAM;
      default:     w_last_bidx = LAST_ACT;
    endcase
  end

  // Command sequencer: header decode, word packing, write pulses, run and readback.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    hdr_d        = hdr_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    widx_d       = widx_q;
    bidx_d       = bidx_q;
    buf_d        = buf_q;
    rdy_d        = 1'b1;
    sel_d        = sel_q;
    en_d         = en_q;
    wea_inst_d   = 1'b0;
    wea_param_d  = 1'b0;
    wea_act_d    = 1'b0;
    inst_data_d  = inst_data_q;
    param_data_d = param_data_q;
    act_data_d   = act_data_q;
    addr_inst_d  = addr_inst_q;
    addr_param_d = addr_param_q;
    addr_act_d   = addr_act_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (w_s_fire) begin
          op_d    = bus.s_data;
          hdr_d   = 2'd0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (w_s_fire) begin
          hdr_d = hdr_q + 2'd1;
          case (hdr_q)
            2'd0: base_d = BASE_W'(bus.s_data);
            2'd1: base_d = BASE_W'({bus.s_data, base_q[7:0]});
            2'd2: cnt_d  = {8'h00, bus.s_data};
            default: begin
              cnt_d  = {bus.s_data, cnt_q[7:0]};
              widx_d = '0;
              bidx_d = '0;
              case (op_q)
                OP_WR_INST, OP_WR_PARAM, OP_WR_ACT: state_d = S_LOAD;
                OP_RUN: begin
                  state_d = S_RUN;
                  sel_d   = 1'b0;
                  en_d    = 1'b1;
                end
                OP_RD_ACT: begin
                  state_d    = S_RD_ADDR;
                  addr_act_d = base_q[WIDTH_ADDR_ACT-1:0];
                end
                default: begin
                  // Unknown opcode: header already consumed, just flag it.
                  state_d = S_IDLE;
                  err_d   = 1'b1;
                end
              endcase
            end
          endcase
        end
      end
      S_LOAD: begin
        if (w_s_fire) begin
          buf_d[{bidx_q, 3'b000} +: 8] = bus.s_data;
          if (bidx_q == w_last_bidx) begin
            bidx_d  = '0;
            state_d = S_WRITE;
            case (op_q)
              OP_WR_INST: begin
                wea_inst_d  = 1'b1;
                inst_data_d = buf_d[WIDTH_INST_MEM-1:0];
                addr_inst_d = base_q[WIDTH_ADDR_INST-1:0] + widx_q[WIDTH_ADDR_INST-1:0];
              end
              OP_WR_PARAM: begin
                wea_param_d  = 1'b1;
                param_data_d = buf_d[WIDTH_PARAM_MEM-1:0];
                addr_param_d = base_q[WIDTH_ADDR_PARAM-1:0] + widx_q[WIDTH_ADDR_PARAM-1:0];
              end
              default: begin
                wea_act_d  = 1'b1;
                act_data_d = buf_d[WIDTH_ACT_MEM-1:0];
                addr_act_d = base_q[WIDTH_ADDR_ACT-1:0] + widx_q[WIDTH_ADDR_ACT-1:0];
              end
            endcase
          end else begin
            bidx_d = bidx_q + BIDX_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (widx_q == cnt_q) begin
          state_d = S_IDLE;
        end else begin
          widx_d  = w_nidx;
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (bus.done) begin
          en_d    = 1'b0;
          sel_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        m_data_d  = 8'(bus.actmem_out);
        m_valid_d = 1'b1;
        state_d   = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          if (widx_q == cnt_q) begin
            state_d = S_IDLE;
          end else begin
            widx_d     = w_nidx;
            addr_act_d = base_q[WIDTH_ADDR_ACT-1:0] + w_nidx[WIDTH_ADDR_ACT-1:0];
            state_d    = S_RD_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any command in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      hdr_q        <= '0;
      base_q       <= '0;
      cnt_q        <= '0;
      widx_q       <= '0;
      bidx_q       <= '0;
      buf_q        <= '0;
      rdy_q        <= 1'b0;
      sel_q        <= 1'b1;
      en_q         <= 1'b0;
      wea_inst_q   <= 1'b0;
      wea_param_q  <= 1'b0;
      wea_act_q    <= 1'b0;
      inst_data_q  <= '0;
      param_data_q <= '0;
      act_data_q   <= '0;
      addr_inst_q  <= '0;
      addr_param_q <= '0;
      addr_act_q   <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      hdr_q        <= hdr_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      widx_q       <= widx_d;
      bidx_q       <= bidx_d;
      buf_q        <= buf_d;
      rdy_q        <= rdy_d;
      sel_q        <= sel_d;
      en_q         <= en_d;
      wea_inst_q   <= wea_inst_d;
      wea_param_q  <= wea_param_d;
      wea_act_q    <= wea_act_d;
      inst_data_q  <= inst_data_d;
      param_data_q <= param_data_d;
      act_data_q   <= act_data_d;
      addr_inst_q  <= addr_inst_d;
      addr_param_q <= addr_param_d;
      addr_act_q   <= addr_act_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      err_q        <= err_d;
    end
  end

  assign bus.s_ready           = w_s_ready;
  assign bus.m_data            = m_data_q;
  assign bus.m_valid           = m_valid_q;
  assign bus.sel_ext           = sel_q;
  assign bus.en                = en_q;
  assign bus.wea_instmem_ext   = wea_inst_q;
  assign bus.wea_parammem_ext  = wea_param_q;
  assign bus.wea_actmem_ext    = wea_act_q;
  assign bus.instmem_in_ext    = inst_data_q;
  assign bus.parammem_in_ext   = param_data_q;
  assign bus.actmem_in_ext     = act_data_q;
  assign bus.addr_instmem_ext  = addr_inst_q;
  assign bus.addr_parammem_ext = addr_param_q;
  assign bus.addr_actmem_ext   = addr_act_q;
  assign bus.busy              = (state_q != S_IDLE);
  assign bus.err               = err_q;
endmodule
`default_nettype wire

// File: tb/tb_host_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  tb_host_loader
//  Directed + randomized bench for host_loader with a command-level model of
//  memory writes and activation readback.
//  Revision: 1.0
// ============================================================================
module tb_host_loader;
  localparam int AW_A = 12;
  localparam int AW_P = 15;
  localparam int AW_I = 6;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  host_loader_if #(.WIDTH_ACT_MEM(8), .WIDTH_PARAM_MEM(128), .WIDTH_INST_MEM(80),
                   .WIDTH_ADDR_ACT(AW_A), .WIDTH_ADDR_PARAM(AW_P), .WIDTH_ADDR_INST(AW_I)) bus ();

  host_loader #(.WIDTH_ACT_MEM(8), .WIDTH_PARAM_MEM(128), .WIDTH_INST_MEM(80),
                .WIDTH_ADDR_ACT(AW_A), .WIDTH_ADDR_PARAM(AW_P), .WIDTH_ADDR_INST(AW_I))
    dut (.clk(clk), .resetn(resetn), .bus(bus.master));

  typedef struct {
    int           kind;
    int           addr;
    logic [127:0] data;
  } wr_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  wr_t          got_q[$];
  logic [7:0]   rx_q[$];
  logic [7:0]   amem    [4096];
  logic [7:0]   ref_act [4096];
  int           wea_cnt = 0;
  int           wea_ready_viol = 0;
  int           stab_viol = 0;
  int           mv_cycles = 0;
  bit           rand_ready = 1'b0;
  logic         prev_hold = 1'b0;
  logic [7:0]   prev_data = 8'h00;

  // Processor activation memory: registered read, one cycle of latency.
  always @(posedge clk) begin
    if (bus.wea_actmem_ext) amem[bus.addr_actmem_ext] <= bus.actmem_in_ext;
    bus.actmem_out <= amem[bus.addr_actmem_ext];
  end

  // Observe write pulses and the readback stream; also drives m_ready.
  always @(negedge clk) begin
    wr_t w;
    if (bus.wea_instmem_ext | bus.wea_parammem_ext | bus.wea_actmem_ext) begin
      wea_cnt++;
      if (bus.s_ready) wea_ready_viol++;
    end
    if (bus.wea_instmem_ext) begin
      w.kind = 1; w.addr = int'(bus.addr_instmem_ext); w.data = 128'(bus.instmem_in_ext);
      got_q.push_back(w);
    end
    if (bus.wea_parammem_ext) begin
      w.kind = 2; w.addr = int'(bus.addr_parammem_ext); w.data = bus.parammem_in_ext;
      got_q.push_back(w);
    end
    if (bus.wea_actmem_ext) begin
      w.kind = 3; w.addr = int'(bus.addr_actmem_ext); w.data = 128'(bus.actmem_in_ext);
      got_q.push_back(w);
    end
    if (bus.m_valid) mv_cycles++;
    if (prev_hold && !(bus.m_valid && (bus.m_data == prev_data))) stab_viol++;
    bus.m_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    prev_hold = bus.m_valid && !bus.m_ready;
    prev_data = bus.m_data;
    if (bus.m_valid && bus.m_ready) rx_q.push_back(bus.m_data);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Offer one byte at a negedge; returns on the negedge after the handshake.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.s_ready) begin
      chk("s_ready_timeout", 128'(bus.s_ready), 128'(1));
      bus.s_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_hdr(input int op, input int base, input int cnt);
    logic [15:0] b16;
    logic [15:0] c16;
    b16 = 16'(base);
    c16 = 16'(cnt);
    send_byte(8'(op));
    send_byte(b16[7:0]);
    send_byte(b16[15:8]);
    send_byte(c16[7:0]);
    send_byte(c16[15:8]);
  endtask

  task automatic wait_idle(output int cycles);
    int t = 0;
    while (bus.busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy) chk("idle_timeout", 128'(bus.busy), 128'(0));
    cycles = t;
  endtask

  // Issue a write command and compare every memory write against the model.
  task automatic do_write(input int op, input int base, input int cnt, input int seq);
    int           nb;
    int           aw;
    int           cyc;
    int           n;
    logic [7:0]   pay[$];
    wr_t          e_q[$];
    wr_t          e;
    logic [127:0] word;
    nb = (op == 1) ? 10 : (op == 2) ? 16 : 1;
    aw = (op == 1) ? AW_I : (op == 2) ? AW_P : AW_A;
    for (int k = 0; k < (cnt + 1) * nb; k++)
      pay.push_back((seq >= 0) ? 8'(seq + k) : 8'($urandom));
    for (int i = 0; i <= cnt; i++) begin
      word = '0;
      for (int k = 0; k < nb; k++) word = word | (128'(pay[i * nb + k]) << (8 * k));
      e.kind = op;
      e.addr = ((base & 16'hFFFF) + i) % (1 << aw);
      e.data = word;
      e_q.push_back(e);
      if (op == 3) ref_act[e.addr] = word[7:0];
    end
    got_q.delete();
    send_hdr(op, base, cnt);
    foreach (pay[k]) send_byte(pay[k]);
    chk($sformatf("op%0d_wea_latency", op),
        128'(bus.wea_instmem_ext | bus.wea_parammem_ext | bus.wea_actmem_ext), 128'(1));
    wait_idle(cyc);
    chk($sformatf("op%0d_nwrites", op), 128'(got_q.size()), 128'(e_q.size()));
    n = (got_q.size() < e_q.size()) ? got_q.size() : e_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("op%0d_w%0d_kind", op, i), 128'(got_q[i].kind), 128'(e_q[i].kind));
      chk($sformatf("op%0d_w%0d_addr", op, i), 128'(got_q[i].addr), 128'(e_q[i].addr));
      chk($sformatf("op%0d_w%0d_data", op, i), got_q[i].data, e_q[i].data);
    end
  endtask

  // Issue a readback command and compare the byte stream against the model.
  task automatic do_read(input int base, input int cnt, input bit rr, output int cyc);
    int n;
    rx_q.delete();
    rand_ready = rr;
    send_hdr(5, base, cnt);
    mv_cycles = 0;
    wait_idle(cyc);
    rand_ready = 1'b0;
    chk("rd_count", 128'(rx_q.size()), 128'(cnt + 1));
    n = (rx_q.size() < cnt + 1) ? rx_q.size() : cnt + 1;
    for (int i = 0; i < n; i++)
      chk($sformatf("rd_byte%0d", i), 128'(rx_q[i]), 128'(ref_act[((base & 16'hFFFF) + i) % 4096]));
  endtask

  initial begin
    int cyc;
    int hold_ok;
    int snap;
    int op;
    int base;
    int cnt;

    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    bus.done    = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      amem[i]    = 8'h00;
      ref_act[i] = 8'h00;
    end

    // Reset state
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 128'(bus.s_ready), 128'(0));
    chk("rst_m_valid", 128'(bus.m_valid), 128'(0));
    chk("rst_m_data",  128'(bus.m_data), 128'(0));
    chk("rst_sel_ext", 128'(bus.sel_ext), 128'(1));
    chk("rst_en",      128'(bus.en), 128'(0));
    chk("rst_wea",     128'({bus.wea_instmem_ext, bus.wea_parammem_ext, bus.wea_actmem_ext}), 128'(0));
    chk("rst_addr",    128'({bus.addr_instmem_ext, bus.addr_parammem_ext, bus.addr_actmem_ext}), 128'(0));
    chk("rst_pdata",   bus.parammem_in_ext, 128'(0));
    chk("rst_idata",   128'({bus.instmem_in_ext, bus.actmem_in_ext}), 128'(0));
    chk("rst_busy",    128'(bus.busy), 128'(0));
    chk("rst_err",     128'(bus.err), 128'(0));
    resetn = 1'b1;
    #1;
    chk("rel_s_ready_before_clk", 128'(bus.s_ready), 128'(0));
    @(negedge clk);
    chk("rel_s_ready_after_clk", 128'(bus.s_ready), 128'(1));

    // Instruction write, sequential payload 00..09
    do_write(1, 16'h0005, 0, 0);
    // Parameter write wrapping past the top of the address space
    do_write(2, 16'h7FFF, 1, -1);
    // Activation write A0..A3 then readback with random backpressure
    do_write(3, 16'h0010, 3, 8'hA0);
    do_read(16'h0010, 3, 1'b1, cyc);
    // Same readback with m_ready held high: one byte every three cycles
    do_read(16'h0010, 3, 1'b0, cyc);
    chk("rd_cycles", 128'(cyc), 128'(12));
    chk("rd_mvalid_cycles", 128'(mv_cycles), 128'(4));

    // Run: en/sel_ext change the cycle after the last header byte
    snap = wea_cnt;
    send_hdr(4, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    chk("run_en",      128'(bus.en), 128'(1));
    chk("run_sel_ext", 128'(bus.sel_ext), 128'(0));
    chk("run_s_ready", 128'(bus.s_ready), 128'(0));
    chk("run_busy",    128'(bus.busy), 128'(1));
    hold_ok = 0;
    for (int c = 0; c < 49; c++) begin
      @(negedge clk);
      if (bus.en && !bus.sel_ext && !bus.s_ready && bus.busy) hold_ok++;
    end
    chk("run_hold", 128'(hold_ok), 128'(49));
    @(negedge clk);
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    chk("run_end_en",      128'(bus.en), 128'(0));
    chk("run_end_sel_ext", 128'(bus.sel_ext), 128'(1));
    chk("run_end_busy",    128'(bus.busy), 128'(0));
    chk("run_no_wea",      128'(wea_cnt), 128'(snap));

    // Spurious done in IDLE
    bus.done = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_done_en",   128'({bus.en, bus.sel_ext, bus.busy}), 128'(3'b010));
    bus.done = 1'b0;
    @(negedge clk);

    // Bad opcode
    snap = wea_cnt;
    send_byte(8'h7E);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h02);
    chk("badop_err_before", 128'(bus.err), 128'(0));
    send_byte(8'h00);
    chk("badop_err",  128'(bus.err), 128'(1));
    chk("badop_busy", 128'(bus.busy), 128'(0));
    repeat (3) @(negedge clk);
    chk("badop_no_wea", 128'(wea_cnt), 128'(snap));
    base = int'($urandom_range(0, 65535));
    do_write(3, base, 2, -1);
    do_read(base, 2, 1'b1, cyc);
    chk("err_sticky", 128'(bus.err), 128'(1));

    // Randomized command mix
    for (int it = 0; it < 6; it++) begin
      op   = int'($urandom_range(1, 3));
      base = int'($urandom_range(0, 65535));
      cnt  = int'($urandom_range(0, 3));
      do_write(op, base, cnt, -1);
      if (op == 3) do_read(base, cnt, 1'b1, cyc);
    end

    // Reset in the middle of a parameter word
    snap = wea_cnt;
    send_hdr(2, int'($urandom_range(0, 65535)), 0);
    for (int k = 0; k < 7; k++) send_byte(8'($urandom));
    resetn = 1'b0;
    #1;
    chk("mid_rst_sel_ext", 128'(bus.sel_ext), 128'(1));
    chk("mid_rst_en",      128'(bus.en), 128'(0));
    chk("mid_rst_s_ready", 128'(bus.s_ready), 128'(0));
    chk("mid_rst_busy",    128'(bus.busy), 128'(0));
    chk("mid_rst_err",     128'(bus.err), 128'(0));
    repeat (3) @(negedge clk);
    chk("mid_rst_s_ready_hold", 128'(bus.s_ready), 128'(0));
    chk("mid_rst_no_wea", 128'(wea_cnt), 128'(snap));
    resetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_s_ready_after", 128'(bus.s_ready), 128'(1));
    do_write(2, int'($urandom_range(0, 65535)), 0, -1);
    base = int'($urandom_range(0, 65535));
    do_write(3, base, 1, -1);
    do_read(base, 1, 1'b0, cyc);
    chk("rd2_cycles", 128'(cyc), 128'(6));

    chk("wea_with_s_ready", 128'(wea_ready_viol), 128'(0));
    chk("m_data_stability", 128'(stab_viol), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
